// File: rtl/mem_line_ctrl.sv
// Cache-line front end for the DDR burst engine.
// Turns one line fill or writeback into one fixed-length burst.
module mem_line_ctrl #(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 24,
  parameter int LINE_BEATS    = 8,
  localparam int LINE_BITS    = LINE_BEATS * MEM_DATA_BITS,
  localparam int OFS_BITS     = $clog2(LINE_BEATS)
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_BITS-1:0]     req_addr,
  input  logic [LINE_BITS-1:0]     req_wdata,
  output logic                     resp_valid,
  output logic                     resp_we,
  output logic [LINE_BITS-1:0]     resp_rdata,
  output logic                     rd_burst_req,
  output logic [9:0]               rd_burst_len,
  output logic [ADDR_BITS-1:0]     rd_burst_addr,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  input  logic                     rd_burst_finish,
  output logic                     wr_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish
);

  localparam int CNT_BITS = OFS_BITS + 1;
  localparam int IDX_BITS = (OFS_BITS > 0) ? OFS_BITS : 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(LINE_BEATS);
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(LINE_BEATS - 1);
  localparam logic [ADDR_BITS-1:0] ALIGN =
    ~(ADDR_BITS'(LINE_BEATS - 1));

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [LINE_BITS-1:0] line_buf;
  logic [CNT_BITS-1:0]  cnt;
  logic                 line_we;
  logic                 accept;
  logic                 cnt_live;
  logic [IDX_BITS-1:0]  rd_idx;
  logic [IDX_BITS-1:0]  wr_idx;

  assign rd_burst_len = 10'(LINE_BEATS);
  assign wr_burst_len = 10'(LINE_BEATS);

  assign accept   = (state == IDLE) && req_valid && req_ready;
  assign cnt_live = (cnt < CNT_MAX);
  assign rd_idx   = cnt[IDX_BITS-1:0];
  // Write requests past the line keep re-presenting the last beat.
  assign wr_idx   = cnt_live ? cnt[IDX_BITS-1:0] : IDX_LAST;

  always_ff @(posedge mem_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = req_we ? WR_BURST : RD_BURST;
      end
      RD_BURST: begin
        if (rd_burst_finish) state_nxt = RESP;
      end
      WR_BURST: begin
        if (wr_burst_finish) state_nxt = RESP;
      end
      RESP: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_we       <= 1'b0;
      resp_rdata    <= '0;
      rd_burst_req  <= 1'b0;
      wr_burst_req  <= 1'b0;
      rd_burst_addr <= '0;
      wr_burst_addr <= '0;
      wr_burst_data <= '0;
      cnt           <= '0;
      line_we       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            rd_burst_addr <= req_addr & ALIGN;
            wr_burst_addr <= req_addr & ALIGN;
            line_we       <= req_we;
            if (req_we) line_buf <= req_wdata;
            req_ready     <= 1'b0;
            cnt           <= '0;
            rd_burst_req  <= ~req_we;
            wr_burst_req  <= req_we;
          end
        end
        RD_BURST: begin
          if (rd_burst_data_valid && cnt_live) begin
            line_buf[rd_idx*MEM_DATA_BITS +: MEM_DATA_BITS]
              <= rd_burst_data;
            cnt <= cnt + CNT_BITS'(1);
          end
          if (rd_burst_finish) rd_burst_req <= 1'b0;
        end
        WR_BURST: begin
          if (wr_burst_data_req) begin
            wr_burst_data <=
              line_buf[wr_idx*MEM_DATA_BITS +: MEM_DATA_BITS];
            if (cnt_live) cnt <= cnt + CNT_BITS'(1);
          end
          if (wr_burst_finish) wr_burst_req <= 1'b0;
        end
        RESP: begin
          resp_valid <= 1'b1;
          resp_we    <= line_we;
          req_ready  <= 1'b1;
          if (!line_we) resp_rdata <= line_buf;
        end
      endcase
    end
  end

  // line_buf is deliberately unreset: every beat is rewritten before use.
  initial begin end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Directed self-checking bench for mem_line_ctrl.
// Acts as the burst engine with hand-scripted beat sequences.
module tb_mem_line_ctrl;

  logic         mem_clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [23:0]  req_addr;
  logic [511:0] req_wdata;
  logic         resp_valid;
  logic         resp_we;
  logic [511:0] resp_rdata;
  logic         rd_burst_req;
  logic [9:0]   rd_burst_len;
  logic [23:0]  rd_burst_addr;
  logic         rd_burst_data_valid;
  logic [63:0]  rd_burst_data;
  logic         rd_burst_finish;
  logic         wr_burst_req;
  logic [9:0]   wr_burst_len;
  logic [23:0]  wr_burst_addr;
  logic         wr_burst_data_req;
  logic [63:0]  wr_burst_data;
  logic         wr_burst_finish;

  int n_chk = 0;
  int n_err = 0;
  int rd_rise = 0;
  int wr_rise = 0;
  logic rd_q = 1'b0;
  logic wr_q = 1'b0;

  mem_line_ctrl dut (
    .mem_clk             (mem_clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_we              (req_we),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .resp_valid          (resp_valid),
    .resp_we             (resp_we),
    .resp_rdata          (resp_rdata),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .rd_burst_finish     (rd_burst_finish),
    .wr_burst_req        (wr_burst_req),
    .wr_burst_len        (wr_burst_len),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_data_req   (wr_burst_data_req),
    .wr_burst_data       (wr_burst_data),
    .wr_burst_finish     (wr_burst_finish)
  );

  always #5 mem_clk = ~mem_clk;

  always @(posedge mem_clk) begin
    rd_q <= rd_burst_req;
    wr_q <= wr_burst_req;
    if (rd_burst_req && !rd_q) rd_rise <= rd_rise + 1;
    if (wr_burst_req && !wr_q) wr_rise <= wr_rise + 1;
  end

  task automatic check(input string tag,
                       input logic [511:0] obs,
                       input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  task automatic send_req(input logic we, input logic [23:0] addr,
                          input logic [511:0] wdata);
    @(negedge mem_clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) break;
      @(negedge mem_clk);
    end
    check("req_accept", 512'(req_ready), 512'(1));
    @(negedge mem_clk);
    req_valid = 1'b0;
  endtask

  task automatic read_beats(input int n, input logic [63:0] base,
                            input logic fin);
    for (int i = 0; i < n; i++) begin
      @(negedge mem_clk);
      rd_burst_data_valid = 1'b1;
      rd_burst_data       = base + 64'(i);
      rd_burst_finish     = fin && (i == n - 1);
    end
    @(negedge mem_clk);
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b0;
  endtask

  task automatic write_beats(input int n, input logic [63:0] base,
                             input int gap, input logic fin);
    for (int k = 0; k < n; k++) begin
      @(negedge mem_clk);
      wr_burst_data_req = 1'b1;
      wr_burst_finish   = fin && (k == n - 1);
      @(negedge mem_clk);
      wr_burst_data_req = 1'b0;
      wr_burst_finish   = 1'b0;
      check("wr_beat", 512'(wr_burst_data),
            512'(base + 64'((k > 7) ? 7 : k)));
      for (int g = 0; g < gap * (k % 3); g++) @(negedge mem_clk);
    end
  endtask

  task automatic wait_resp(input logic we, input logic [511:0] rdata);
    for (int i = 0; i < 50; i++) begin
      if (resp_valid) break;
      @(negedge mem_clk);
    end
    check("resp_valid", 512'(resp_valid), 512'(1));
    check("resp_we", 512'(resp_we), 512'(we));
    check("resp_rdata", resp_rdata, rdata);
    check("ready_at_resp", 512'(req_ready), 512'(1));
    @(negedge mem_clk);
    check("resp_pulse", 512'(resp_valid), 512'(0));
  endtask

  initial begin
    int r0, w0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rd_burst_data_valid = 1'b0;
    rd_burst_data = '0;
    rd_burst_finish = 1'b0;
    wr_burst_data_req = 1'b0;
    wr_burst_finish = 1'b0;
    repeat (3) @(negedge mem_clk);
    rst = 1'b0;
    check("rst_ready", 512'(req_ready), 512'(1));
    check("rst_resp_valid", 512'(resp_valid), 512'(0));
    check("rst_rd_req", 512'(rd_burst_req), 512'(0));
    check("rst_wr_req", 512'(wr_burst_req), 512'(0));
    check("rst_wr_data", 512'(wr_burst_data), 512'(0));
    check("rst_rdata", resp_rdata, 512'(0));
    check("rd_len", 512'(rd_burst_len), 512'(8));
    check("wr_len", 512'(wr_burst_len), 512'(8));

    // 1: aligned read fill
    send_req(1'b0, 24'h000013, '0);
    check("t1_rd_req", 512'(rd_burst_req), 512'(1));
    check("t1_rd_addr", 512'(rd_burst_addr), 512'(24'h000010));
    check("t1_busy", 512'(req_ready), 512'(0));
    read_beats(8, 64'h1, 1'b1);
    check("t1_rd_req_drop", 512'(rd_burst_req), 512'(0));
    check("t1_no_early_resp", 512'(resp_valid), 512'(0));
    wait_resp(1'b0, mk_line(64'h1));

    // finishes outside a burst are ignored
    @(negedge mem_clk);
    rd_burst_finish = 1'b1;
    wr_burst_finish = 1'b1;
    @(negedge mem_clk);
    rd_burst_finish = 1'b0;
    wr_burst_finish = 1'b0;
    @(negedge mem_clk);
    check("idle_fin_ready", 512'(req_ready), 512'(1));
    check("idle_fin_resp", 512'(resp_valid), 512'(0));

    // 2: gapped writeback
    send_req(1'b1, 24'h000127, mk_line(64'hA0));
    check("t2_wr_req", 512'(wr_burst_req), 512'(1));
    check("t2_wr_addr", 512'(wr_burst_addr), 512'(24'h000120));
    check("t2_no_rd_req", 512'(rd_burst_req), 512'(0));
    write_beats(8, 64'hA0, 1, 1'b0);
    @(negedge mem_clk);
    wr_burst_finish = 1'b1;
    @(negedge mem_clk);
    wr_burst_finish = 1'b0;
    check("t2_wr_req_drop", 512'(wr_burst_req), 512'(0));
    wait_resp(1'b1, mk_line(64'h1));

    // 3: back-to-back write then read, req_valid held
    r0 = rd_rise;
    w0 = wr_rise;
    @(negedge mem_clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 24'h000200;
    req_wdata = mk_line(64'hB0);
    @(negedge mem_clk);
    req_we   = 1'b0;
    req_addr = 24'h00030C;
    check("t3_wr_req", 512'(wr_burst_req), 512'(1));
    check("t3_busy", 512'(req_ready), 512'(0));
    write_beats(8, 64'hB0, 0, 1'b1);
    check("t3_still_busy", 512'(req_ready), 512'(0));
    @(negedge mem_clk);
    check("t3_resp_valid", 512'(resp_valid), 512'(1));
    check("t3_resp_we", 512'(resp_we), 512'(1));
    check("t3_ready", 512'(req_ready), 512'(1));
    @(negedge mem_clk);
    req_valid = 1'b0;
    check("t3_rd_req", 512'(rd_burst_req), 512'(1));
    check("t3_rd_addr", 512'(rd_burst_addr), 512'(24'h000308));
    check("t3_wr_idle", 512'(wr_burst_req), 512'(0));
    read_beats(8, 64'hC0, 1'b1);
    wait_resp(1'b0, mk_line(64'hC0));
    repeat (3) @(negedge mem_clk);
    check("t3_one_rd", 512'(rd_rise - r0), 512'(1));
    check("t3_one_wr", 512'(wr_rise - w0), 512'(1));

    // 4: surplus ninth beat is dropped
    send_req(1'b0, 24'h000040, '0);
    read_beats(9, 64'h90, 1'b1);
    wait_resp(1'b0, mk_line(64'h90));

    // 5: reset in the middle of a read burst
    send_req(1'b0, 24'h000400, '0);
    read_beats(3, 64'h11, 1'b0);
    rst = 1'b1;
    @(negedge mem_clk);
    rst = 1'b0;
    check("t5_ready", 512'(req_ready), 512'(1));
    check("t5_rd_req", 512'(rd_burst_req), 512'(0));
    check("t5_resp_valid", 512'(resp_valid), 512'(0));
    check("t5_rdata", resp_rdata, 512'(0));
    send_req(1'b0, 24'h000408, '0);
    check("t5_rd_addr", 512'(rd_burst_addr), 512'(24'h000408));
    read_beats(8, 64'h60, 1'b1);
    wait_resp(1'b0, mk_line(64'h60));

    // 6: request while busy waits for the response cycle
    send_req(1'b0, 24'h000500, '0);
    @(negedge mem_clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 24'h000605;
    req_wdata = mk_line(64'hD0);
    repeat (3) @(negedge mem_clk);
    check("t6_busy", 512'(req_ready), 512'(0));
    check("t6_no_wr", 512'(wr_burst_req), 512'(0));
    read_beats(8, 64'hE0, 1'b1);
    check("t6_busy_resp", 512'(req_ready), 512'(0));
    @(negedge mem_clk);
    check("t6_resp_valid", 512'(resp_valid), 512'(1));
    check("t6_rdata", resp_rdata, mk_line(64'hE0));
    check("t6_ready", 512'(req_ready), 512'(1));
    @(negedge mem_clk);
    req_valid = 1'b0;
    check("t6_wr_req", 512'(wr_burst_req), 512'(1));
    check("t6_wr_addr", 512'(wr_burst_addr), 512'(24'h000600));
    write_beats(9, 64'hD0, 0, 1'b1);
    wait_resp(1'b1, mk_line(64'hE0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
